memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 92 +++++++++
 tb/tb_memory.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Unified instruction/data RAM with a byte-stream program loader.
// Core reset stays asserted until the image has been fully streamed in.
module memory #(
  parameter int MEM_BYTES = 16384,
  parameter int WORD_LEN  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_LEN-1:0] addr_i,
  output logic [WORD_LEN-1:0] inst,
  input  logic [WORD_LEN-1:0] addr_d,
  output logic [WORD_LEN-1:0] rdata,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [7:0]          ld_byte,
  input  logic                ld_last,
  output logic                ld_ovf,
  output logic                core_rst_n
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int NB = WORD_LEN / 8;
  localparam int BW = $clog2(NB);

  typedef enum logic [1:0] {LOAD, DONE, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ovf_q, ovf_d;
  logic            core_rst_q;
  logic [7:0]      mem_q [MEM_BYTES];

  logic            ld_acc, core_we;
  logic [AW-BW-1:0] iw, dw;

  assign ld_ready   = (state_q == LOAD);
  assign ld_acc     = ld_valid & ld_ready;
  assign core_we    = wen & (state_q == RUN);
  assign ld_ovf     = ovf_q;
  assign core_rst_n = core_rst_q;
  assign iw         = addr_i[AW-1:BW];
  assign dw         = addr_d[AW-1:BW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    case (state_q)
      LOAD: if (ld_acc) begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == {AW{1'b1}} && !ld_last) ovf_d = 1'b1;
        if (ld_last) state_d = DONE;
      end
      DONE:    state_d = RUN;
      default: ;
    endcase
  end

  // core_rst_n comes straight from a flop so release is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      core_rst_q <= (state_d == RUN);
    end
  end

  // Contents survive reset; loader and core writes are mutually exclusive by state
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      mem_q[ptr_q] <= ld_byte;
    end else if (core_we) begin
      for (int k = 0; k < NB; k++) mem_q[{dw, BW'(k)}] <= wdata[8*k +: 8];
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign inst[8*b +: 8]  = mem_q[{iw, BW'(b)}];
    assign rdata[8*b +: 8] = mem_q[{dw, BW'(b)}];
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[WORD_LEN-1:AW], addr_i[BW-1:0],
                              addr_d[WORD_LEN-1:AW], addr_d[BW-1:0]};
endmodule

// File: tb/tb_memory.sv
// Randomized bench for memory: a 16 KiB and a 16 B instance against a byte-array model.
module tb_memory;
  localparam int N0 = 16384;
  localparam int N1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [31:0] addr_i [2], inst [2], addr_d [2], rdata [2], wdata [2];
  logic        wen [2], ld_valid [2], ld_ready [2], ld_last [2], ld_ovf [2], core_rst_n [2];
  logic [7:0]  ld_byte [2];

  memory u0 (
    .clk(clk), .rst_n(rst_n[0]), .addr_i(addr_i[0]), .inst(inst[0]),
    .addr_d(addr_d[0]), .rdata(rdata[0]), .wen(wen[0]), .wdata(wdata[0]),
    .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]), .ld_byte(ld_byte[0]),
    .ld_last(ld_last[0]), .ld_ovf(ld_ovf[0]), .core_rst_n(core_rst_n[0])
  );

  memory #(.MEM_BYTES(N1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .addr_i(addr_i[1]), .inst(inst[1]),
    .addr_d(addr_d[1]), .rdata(rdata[1]), .wen(wen[1]), .wdata(wdata[1]),
    .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]), .ld_byte(ld_byte[1]),
    .ld_last(ld_last[1]), .ld_ovf(ld_ovf[1]), .core_rst_n(core_rst_n[1])
  );

  // Model: byte array with a "written" flag, plus phase 0=load 1=done 2=run
  logic [7:0] mm [2][N0];
  bit         kn [2][N0];
  int         mode [2];
  int         ptr [2];
  bit         ovf [2];
  int         nb [2] = '{N0, N1};
  int         nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit mword(input int d, input logic [31:0] a, output logic [31:0] w);
    int base;
    base = int'(a[15:0]) % nb[d];
    base = base - (base % 4);
    w = {mm[d][base+3], mm[d][base+2], mm[d][base+1], mm[d][base]};
    return kn[d][base] && kn[d][base+1] && kn[d][base+2] && kn[d][base+3];
  endfunction

  task automatic check_out(input int d);
    logic [31:0] w;
    chk($sformatf("u%0d.ld_ready", d), {31'b0, ld_ready[d]}, {31'b0, mode[d] == 0});
    chk($sformatf("u%0d.core_rst_n", d), {31'b0, core_rst_n[d]}, {31'b0, mode[d] == 2});
    chk($sformatf("u%0d.ld_ovf", d), {31'b0, ld_ovf[d]}, {31'b0, ovf[d]});
    if (mword(d, addr_i[d], w)) chk($sformatf("u%0d.inst@%h", d, addr_i[d]), inst[d], w);
    if (mword(d, addr_d[d], w)) chk($sformatf("u%0d.rdata@%h", d, addr_d[d]), rdata[d], w);
  endtask

  task automatic model_edge(input int d);
    int m, base;
    m = mode[d];
    if (m == 0 && ld_valid[d]) begin
      mm[d][ptr[d]] = ld_byte[d];
      kn[d][ptr[d]] = 1'b1;
      if (ptr[d] == nb[d] - 1 && !ld_last[d]) ovf[d] = 1'b1;
      ptr[d] = (ptr[d] + 1) % nb[d];
      if (ld_last[d]) mode[d] = 1;
    end else if (m == 1) begin
      mode[d] = 2;
    end
    if (m == 2 && wen[d]) begin
      base = int'(addr_d[d][15:0]) % nb[d];
      base = base - (base % 4);
      for (int k = 0; k < 4; k++) begin
        mm[d][base+k] = wdata[d][8*k +: 8];
        kn[d][base+k] = 1'b1;
      end
    end
  endtask

  // Called at posedge+1: settle, check old state, clock, check new state
  task automatic step();
    #1;
    check_out(0); check_out(1);
    model_edge(0); model_edge(1);
    @(posedge clk); #1;
    check_out(0); check_out(1);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    #1;
    mode[d] = 0; ptr[d] = 0; ovf[d] = 1'b0;
    check_out(d);
    rst_n[d] = 1'b1;
    #1;
  endtask

  task automatic idle(input int d);
    ld_valid[d] = 1'b0; ld_last[d] = 1'b0; wen[d] = 1'b0;
  endtask

  task automatic load(input int d, input logic [7:0] b, input bit last);
    ld_valid[d] = 1'b1; ld_byte[d] = b; ld_last[d] = last;
    step();
    ld_valid[d] = 1'b0; ld_last[d] = 1'b0;
  endtask

  logic [7:0] img [8];

  initial begin
    img = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    for (int d = 0; d < 2; d++) begin
      idle(d);
      addr_i[d] = '0; addr_d[d] = '0; wdata[d] = '0; ld_byte[d] = '0;
      mode[d] = 0; ptr[d] = 0; ovf[d] = 1'b0;
      rst_n[d] = 1'b1;
    end
    #1;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #1;
    check_out(0); check_out(1);
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Image load, with a core write attempted mid-load that must be ignored
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin wen[0] = 1'b1; addr_d[0] = 32'h0; wdata[0] = 32'hFFFF_FFFF; end
      load(0, img[i], i == 7);
      wen[0] = 1'b0;
    end
    chk("done.core_rst_n", {31'b0, core_rst_n[0]}, 32'd0);
    chk("done.ld_ready", {31'b0, ld_ready[0]}, 32'd0);
    step();
    chk("run.core_rst_n", {31'b0, core_rst_n[0]}, 32'd1);
    addr_i[0] = 32'h0; #1 chk("inst@0", inst[0], 32'h0000_0513);
    addr_i[0] = 32'h4; #1 chk("inst@4", inst[0], 32'h00A0_0093);
    addr_i[0] = 32'h6; #1 chk("inst@6", inst[0], 32'h00A0_0093);
    step();

    // Reset in RUN, partial load, reset mid-load, one-byte reload
    do_reset(0);
    chk("rst_in_run.core_rst_n", {31'b0, core_rst_n[0]}, 32'd0);
    load(0, 8'hAA, 0); load(0, 8'hBB, 0); load(0, 8'hCC, 0);
    do_reset(0);
    load(0, 8'h11, 1);
    step();
    addr_i[0] = 32'h0; #1 chk("reload.word0", inst[0], 32'h00CC_BB11);
    chk("reload.core_rst_n", {31'b0, core_rst_n[0]}, 32'd1);

    // Core store then load, including read-during-write
    addr_d[0] = 32'h100; wdata[0] = 32'hDEAD_BEEF; wen[0] = 1'b1;
    step();
    wen[0] = 1'b0;
    #1 chk("st.rdata@100", rdata[0], 32'hDEAD_BEEF);
    addr_d[0] = 32'h102; #1 chk("st.rdata@102", rdata[0], 32'hDEAD_BEEF);
    addr_i[0] = 32'h100; #1 chk("st.inst@100", inst[0], 32'hDEAD_BEEF);
    step();
    addr_d[0] = 32'h100; wdata[0] = 32'h1234_5678; wen[0] = 1'b1;
    #1 chk("rdw.old", rdata[0], 32'hDEAD_BEEF);
    step();
    wen[0] = 1'b0;
    chk("rdw.new", rdata[0], 32'h1234_5678);

    // Loader traffic in RUN must be ignored
    addr_i[0] = 32'h0;
    ld_valid[0] = 1'b1; ld_byte[0] = 8'h5A; ld_last[0] = 1'b1;
    repeat (10) step();
    idle(0);
    chk("bp.word0", inst[0], 32'h00CC_BB11);
    chk("bp.ovf", {31'b0, ld_ovf[0]}, 32'd0);

    // Overflow on the 16-byte instance
    do_reset(1);
    for (int i = 1; i <= 17; i++) begin
      load(1, 8'(i), i == 17);
      if (i == 15) chk("ovf.before", {31'b0, ld_ovf[1]}, 32'd0);
      if (i == 16) chk("ovf.after16", {31'b0, ld_ovf[1]}, 32'd1);
    end
    addr_i[1] = 32'h0; #1 chk("ovf.word0", inst[1], 32'h0403_0211);
    step();

    // Randomized traffic on both instances
    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 99) == 0) do_reset(d);
        idle(d);
        addr_i[d] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 'h3ff));
        addr_d[d] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 'h3ff));
        wdata[d]  = $urandom();
        ld_byte[d] = 8'($urandom());
        ld_valid[d] = $urandom_range(0, 1) == 1;
        ld_last[d]  = $urandom_range(0, (d == 0) ? 24 : 12) == 0;
        wen[d]      = $urandom_range(0, 2) == 0;
      end
      step();
    end
    idle(0); idle(1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
